lfsr6s3_chk: RTL and testbench
==============================

// Module: lfsr6s3_chk
// PURPOSE
//  Downstream PRBS checker for the 3-bit/step length-6 XNOR LFSR (x^6+x^5+1, 63-state period).
//  Consumes the 3 fresh bits the generator produces per step (gen y[3:1]) under a valid strobe.
//  Acquires sync, then free-runs its own reference LFSR and counts bit errors.
//  Used for loop-back/BER tests of the LFSR datapath.
// PARAMETERS
//  LOCK_CNT  4   consecutive matching words in SEARCH needed to lock (>=2)
//  LOSS_CNT  3   consecutive erroneous words in LOCKED that drop lock (>=1)
//  CNT_W     16  width of bit-error counter
// PORTS
//  clk          in   1      rising-edge clock, single clock domain
//  reset_n      in   1      asynchronous, active-low reset
//  din_valid    in   1      din carries a new generator step this cycle
//  din          in   3      newest 3 bits of the generator state (gen y[3:1])
//  clr_cnt      in   1      synchronous clear of err_cnt
//  locked       out  1      checker in LOCKED state
//  err_pulse    out  1      registered: last valid word had >=1 bit error while LOCKED
//  err_bits     out  2      registered popcount (0..3) of that word's mismatches
//  err_cnt      out  CNT_W  saturating total bit errors since lock/clear
// BEHAVIOUR
//  Reset (async, reset_n=0): state=SEARCH, ref=6'b0, prev=3'b0, match/miss counters=0,
//   locked=0, err_pulse=0, err_bits=0, err_cnt=0.
//  All state advances only on cycles with din_valid=1; din_valid=0 -> everything holds,
//   err_pulse/err_bits drop to 0.
//  Prediction from state S[6:1]: p[3]=S5~^S6, p[2]=S4~^S5, p[1]=S3~^S4; next S={S[3:1],p}.
//  SEARCH: S={prev,din_prev_word}. Each valid word: compare din to prediction from
//   {prev_prev,prev}; match -> match_cnt+1, mismatch -> match_cnt=0. Always reload from data.
//   Words that make S=6'b111111 (XNOR lockup) never count as match; match_cnt=0.
//   First valid word after reset/lock loss only primes prev; it is never compared.
//   When match_cnt reaches LOCK_CNT: -> LOCKED next edge, ref loaded with {prev,din}, err_cnt=0.
//  LOCKED: ref advances autonomously per valid word (never reloaded from din).
//   mism=din^pred(ref); err_bits<=popcount(mism); err_pulse<=|mism (1-cycle latency).
//   err_cnt += popcount, saturating at 2^CNT_W-1 (no wrap).
//   miss_cnt counts consecutive words with mism!=0, cleared by clean word; reaching LOSS_CNT
//   -> SEARCH next edge, locked=0, match_cnt=0, err_cnt holds its value.
//  locked is registered: rises on the edge that consumes the LOCK_CNT-th match.
//  clr_cnt=1: err_cnt<=popcount of the same-cycle LOCKED word (0 if none); clear wins over add.
//  Errors in SEARCH are never counted; err_pulse=0 in SEARCH.
//  Single flipped bit in LOCKED yields exactly one counted bit (free-running ref, no propagation).
//  Reset asserted mid-operation: immediate return to reset values regardless of state.
// TESTING
//  T1 reset then clean stream from gen state 0: words 111,110,... -> locked=1 after
//     LOCK_CNT+1 valid words; err_cnt stays 0 for 200 words.
//  T2 locked, flip din[2] on one word -> err_pulse=1, err_bits=1 next cycle, err_cnt=1,
//     locked stays 1; subsequent words clean.
//  T3 locked, invert all 3 bits for LOSS_CNT=3 words -> err_cnt=9, locked=0 after 3rd word;
//     resume clean stream -> relock after LOCK_CNT+1 words, err_cnt reset to 0.
//  T4 din held 111 (lockup) with din_valid=1 for 20 words -> locked stays 0.
//  T5 CNT_W=4, inject 20 single-bit errors (spaced by clean words) -> err_cnt saturates at 15;
//     clr_cnt with same-cycle 2-bit error -> err_cnt=2.
//  T6 gaps: din_valid toggled 1/0 randomly on clean stream -> locks, zero errors;
//     reset_n pulsed low while locked -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lfsr6s3_chk.sv
// PRBS checker for the 3-bit/step, length-6 XNOR LFSR (x^6+x^5+1).
// Searches for sync by predicting each incoming word from the previous two,
// locks after LOCK_CNT consecutive good predictions, then free-runs its own
// reference LFSR and counts bit errors against it.
//
// Handshake: din is consumed on every rising clk edge where din_valid=1.
// There is no backpressure. Cycles with din_valid=0 hold all state and
// force err_pulse/err_bits to 0 on the following edge.
module lfsr6s3_chk #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din_valid,
    input  logic [2:0]       din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [1:0]       err_bits,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Three fresh bits from a 6-bit state S[6:1] (held here as s[5:0]).
    function automatic logic [2:0] predict(input logic [5:0] s);
        return {s[4] ~^ s[5], s[3] ~^ s[4], s[2] ~^ s[3]};
    endfunction

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // lfsr holds the data history while searching and doubles as the
    // free-running reference once locked. Because it keeps advancing on the
    // correct sequence right up to the loss edge, the history after a lock
    // loss is already the good one and the next word only needs priming.
    state_t               state, state_next;
    logic [5:0]           lfsr, lfsr_next;
    logic                 primed, primed_next;
    logic [MATCH_W-1:0]   match_cnt, match_cnt_next;
    logic [MISS_W-1:0]    miss_cnt, miss_cnt_next;
    logic                 lock_evt;

    logic [2:0]           pred;
    logic [2:0]           mism;
    logic [1:0]           mism_bits;
    logic [5:0]           load_st;
    logic                 word_match;
    logic                 locked_word;

    logic [1:0]           add_bits;
    logic [CNT_W:0]       cnt_sum;
    logic [CNT_W-1:0]     err_cnt_next;
    logic                 err_pulse_next;
    logic [1:0]           err_bits_next;

    // Prediction and comparison of the current word against the held state.
    always_comb begin
        pred        = predict(lfsr);
        mism        = din ^ pred;
        mism_bits   = popcount3(mism);
        load_st     = {lfsr[2:0], din};
        // All-ones is the XNOR lockup state and is never a valid match.
        word_match  = primed && (din == pred) && (load_st != 6'b111111);
        locked_word = din_valid && (state == ST_LOCKED);
    end

    // Next-state logic: search/lock FSM, history/reference and run counters.
    always_comb begin
        state_next     = state;
        lfsr_next      = lfsr;
        primed_next    = primed;
        match_cnt_next = match_cnt;
        miss_cnt_next  = miss_cnt;
        lock_evt       = 1'b0;

        if (din_valid) begin
            case (state)
                ST_SEARCH: begin
                    lfsr_next   = load_st;
                    primed_next = 1'b1;
                    if (word_match) begin
                        if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                            state_next     = ST_LOCKED;
                            match_cnt_next = '0;
                            miss_cnt_next  = '0;
                            lock_evt       = 1'b1;
                        end else begin
                            match_cnt_next = match_cnt + MATCH_W'(1);
                        end
                    end else begin
                        match_cnt_next = '0;
                    end
                end
                ST_LOCKED: begin
                    lfsr_next = {lfsr[2:0], pred};
                    if (mism != 3'b000) begin
                        if (miss_cnt == MISS_W'(LOSS_CNT - 1)) begin
                            state_next     = ST_SEARCH;
                            primed_next    = 1'b0;
                            match_cnt_next = '0;
                            miss_cnt_next  = '0;
                        end else begin
                            miss_cnt_next = miss_cnt + MISS_W'(1);
                        end
                    end else begin
                        miss_cnt_next = '0;
                    end
                end
                default: begin
                    state_next = ST_SEARCH;
                end
            endcase
        end
    end

    // Error reporting and the saturating bit-error counter.
    always_comb begin
        add_bits       = locked_word ? mism_bits : 2'd0;
        err_pulse_next = locked_word && (mism != 3'b000);
        err_bits_next  = add_bits;
        cnt_sum        = {1'b0, err_cnt} + {{(CNT_W-1){1'b0}}, add_bits};
        if (clr_cnt) begin
            err_cnt_next = {{(CNT_W-2){1'b0}}, add_bits};
        end else if (lock_evt) begin
            err_cnt_next = '0;
        end else if (cnt_sum[CNT_W]) begin
            err_cnt_next = '1;
        end else begin
            err_cnt_next = cnt_sum[CNT_W-1:0];
        end
    end

    // State register for the FSM and its datapath.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_SEARCH;
            lfsr      <= 6'b000000;
            primed    <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            state     <= state_next;
            lfsr      <= lfsr_next;
            primed    <= primed_next;
            match_cnt <= match_cnt_next;
            miss_cnt  <= miss_cnt_next;
        end
    end

    // Registered error outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_pulse <= 1'b0;
            err_bits  <= 2'd0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= err_pulse_next;
            err_bits  <= err_bits_next;
            err_cnt   <= err_cnt_next;
        end
    end

    assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_lfsr6s3_chk.sv
// Directed bench for lfsr6s3_chk: acquisition, single-bit errors, lock loss
// and relock, lockup rejection, counter saturation/clear, gaps and async reset.
module tb_lfsr6s3_chk;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        din_valid = 1'b0;
    logic [2:0]  din = 3'b000;
    logic        clr_cnt = 1'b0;

    logic        locked, err_pulse;
    logic [1:0]  err_bits;
    logic [15:0] err_cnt;

    logic        s_locked, s_err_pulse;
    logic [1:0]  s_err_bits;
    logic [3:0]  s_err_cnt;

    int total = 0;
    int bad = 0;
    logic [5:0] gen = 6'd0;

    lfsr6s3_chk #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .din_valid(din_valid), .din(din),
        .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_bits(err_bits), .err_cnt(err_cnt)
    );

    lfsr6s3_chk #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .din_valid(din_valid), .din(din),
        .clr_cnt(clr_cnt), .locked(s_locked), .err_pulse(s_err_pulse),
        .err_bits(s_err_bits), .err_cnt(s_err_cnt)
    );

    // clock
    always #5 clk = ~clk;

    // generator reference: next 3-bit word from the bench's own LFSR
    task automatic next_word(output logic [2:0] w);
        w   = {gen[4] ~^ gen[5], gen[3] ~^ gen[4], gen[2] ~^ gen[3]};
        gen = {gen[2:0], w};
    endtask

    task automatic send(input logic [2:0] w, input logic clr);
        @(negedge clk);
        din_valid = 1'b1;
        din       = w;
        clr_cnt   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
            din       = 3'($urandom_range(0, 7));
            clr_cnt   = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        gen     = 6'd0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err_pulse got=%b exp=0", err_pulse); end
        total++; if (err_bits !== 2'd0) begin bad++; $display("FAIL reset_err_bits got=%0d exp=0", err_bits); end
        total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        // valid words while held in reset must be ignored
        @(negedge clk);
        din_valid = 1'b1;
        din       = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        total++; if (s_err_cnt !== 4'd0) begin bad++; $display("FAIL reset_hold_cnt got=%0d exp=0", s_err_cnt); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_hold_locked got=%b exp=0", locked); end
        @(negedge clk);
        din_valid = 1'b0;
        reset_n   = 1'b1;
        gen       = 6'd0;
    endtask

    // T1: clean stream from generator state 0 (111, 110, 111, 100, ...)
    task automatic test_acquire();
        logic [2:0] w;
        for (int k = 1; k <= 5; k++) begin
            next_word(w);
            send(w, 1'b0);
            total++; if (locked !== (k == 5)) begin bad++; $display("FAIL acq_locked word=%0d got=%b exp=%b", k, locked, (k == 5)); end
        end
        for (int k = 0; k < 200; k++) begin
            next_word(w);
            send(w, 1'b0);
            total++; if (err_pulse !== 1'b0 || err_bits !== 2'd0) begin bad++; $display("FAIL clean_err word=%0d pulse=%b bits=%0d exp=0/0", k, err_pulse, err_bits); end
        end
        total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL clean_err_cnt got=%0d exp=0", err_cnt); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL clean_locked got=%b exp=1", locked); end
    endtask

    // T2: one flipped bit on din[2]
    task automatic test_single_flip();
        logic [2:0] w;
        next_word(w);
        send(w ^ 3'b100, 1'b0);
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL flip_pulse got=%b exp=1", err_pulse); end
        total++; if (err_bits !== 2'd1) begin bad++; $display("FAIL flip_bits got=%0d exp=1", err_bits); end
        total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL flip_cnt got=%0d exp=1", err_cnt); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL flip_locked got=%b exp=1", locked); end
        for (int k = 0; k < 3; k++) begin
            next_word(w);
            send(w, 1'b0);
            total++; if (err_pulse !== 1'b0 || err_cnt !== 16'd1) begin bad++; $display("FAIL flip_after word=%0d pulse=%b cnt=%0d exp=0/1", k, err_pulse, err_cnt); end
        end
    endtask

    // T3: LOSS_CNT fully inverted words, then relock
    task automatic test_loss_relock();
        logic [2:0] w;
        next_word(w);
        send(w, 1'b1);
        total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL clr_clean got=%0d exp=0", err_cnt); end
        for (int i = 1; i <= 3; i++) begin
            next_word(w);
            send(~w, 1'b0);
            total++; if (err_cnt !== 16'(3 * i)) begin bad++; $display("FAIL loss_cnt word=%0d got=%0d exp=%0d", i, err_cnt, 3 * i); end
            total++; if (err_bits !== 2'd3) begin bad++; $display("FAIL loss_bits word=%0d got=%0d exp=3", i, err_bits); end
            total++; if (locked !== (i < 3)) begin bad++; $display("FAIL loss_locked word=%0d got=%b exp=%b", i, locked, (i < 3)); end
        end
        for (int k = 1; k <= 5; k++) begin
            next_word(w);
            send(w, 1'b0);
            total++; if (locked !== (k == 5)) begin bad++; $display("FAIL relock word=%0d got=%b exp=%b", k, locked, (k == 5)); end
            if (k < 5) begin
                total++; if (err_cnt !== 16'd9 || err_pulse !== 1'b0) begin bad++; $display("FAIL search_hold word=%0d cnt=%0d pulse=%b exp=9/0", k, err_cnt, err_pulse); end
            end else begin
                total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL relock_cnt got=%0d exp=0", err_cnt); end
            end
        end
    endtask

    // T4: XNOR lockup pattern never locks
    task automatic test_lockup();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            send(3'b111, 1'b0);
            total++; if (locked !== 1'b0 || err_pulse !== 1'b0) begin bad++; $display("FAIL lockup word=%0d locked=%b pulse=%b exp=0/0", k, locked, err_pulse); end
        end
        total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL lockup_cnt got=%0d exp=0", err_cnt); end
    endtask

    // T5: saturation of a 4-bit counter, then clear with a same-cycle 2-bit error
    task automatic test_saturate();
        logic [2:0] w;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            next_word(w);
            send(w, 1'b0);
        end
        total++; if (s_locked !== 1'b1) begin bad++; $display("FAIL sat_lock got=%b exp=1", s_locked); end
        for (int k = 1; k <= 20; k++) begin
            next_word(w);
            send(w ^ 3'b001, 1'b0);
            total++; if (s_err_cnt !== 4'((k > 15) ? 15 : k)) begin bad++; $display("FAIL sat_small err=%0d got=%0d exp=%0d", k, s_err_cnt, (k > 15) ? 15 : k); end
            total++; if (err_cnt !== 16'(k)) begin bad++; $display("FAIL sat_wide err=%0d got=%0d exp=%0d", k, err_cnt, k); end
            next_word(w);
            send(w, 1'b0);
        end
        next_word(w);
        send(w ^ 3'b011, 1'b1);
        total++; if (s_err_cnt !== 4'd2) begin bad++; $display("FAIL clr_small got=%0d exp=2", s_err_cnt); end
        total++; if (err_cnt !== 16'd2) begin bad++; $display("FAIL clr_wide got=%0d exp=2", err_cnt); end
        total++; if (err_bits !== 2'd2) begin bad++; $display("FAIL clr_bits got=%0d exp=2", err_bits); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL clr_locked got=%b exp=1", locked); end
    endtask

    // T6: random valid gaps, idle drops err_pulse, async reset while locked
    task automatic test_gaps();
        logic [2:0] w;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            idle($urandom_range(0, 2));
            next_word(w);
            send(w, 1'b0);
            total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL gap_pulse word=%0d got=%b exp=0", k, err_pulse); end
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL gap_locked got=%b exp=1", locked); end
        total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL gap_cnt got=%0d exp=0", err_cnt); end
        next_word(w);
        send(w ^ 3'b010, 1'b0);
        idle(1);
        total++; if (err_pulse !== 1'b0 || err_bits !== 2'd0) begin bad++; $display("FAIL idle_drop pulse=%b bits=%0d exp=0/0", err_pulse, err_bits); end
        total++; if (err_cnt !== 16'd1 || locked !== 1'b1) begin bad++; $display("FAIL idle_hold cnt=%0d locked=%b exp=1/1", err_cnt, locked); end
        @(negedge clk);
        #2;
        reset_n   = 1'b0;
        din_valid = 1'b0;
        #1;
        total++; if (locked !== 1'b0 || err_cnt !== 16'd0) begin bad++; $display("FAIL async_reset locked=%b cnt=%0d exp=0/0", locked, err_cnt); end
        total++; if (err_pulse !== 1'b0 || err_bits !== 2'd0) begin bad++; $display("FAIL async_reset_err pulse=%b bits=%0d exp=0/0", err_pulse, err_bits); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_single_flip();
        test_loss_relock();
        test_lockup();
        test_saturate();
        test_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
